// File: rtl/multdiv_pkg.sv
// ---------------------------------------------------------------------------
// multdiv_pkg
//   Shared definitions for the iterative multiply/divide control sequencer:
//   FSM state encoding, default iteration counts and default counter width.
// ---------------------------------------------------------------------------
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_MULT_STEPS = 32;
    localparam int DEF_DIV_STEPS  = 32;
    localparam int DEF_CNT_W      = 6;

endpackage : multdiv_pkg

// File: rtl/down_counter_load.sv
// ---------------------------------------------------------------------------
// down_counter_load
//   Loadable down-counter with terminal-count flag.
//   Ports:
//     clk       rising-edge clock
//     reset     asynchronous active-high reset (value -> 0)
//     load      synchronous load of load_val (priority over decrement)
//     load_val  value to load
//     en        decrement enable
//     value     current count
//     tc        terminal count, high when value == 0
// ---------------------------------------------------------------------------
module down_counter_load
    import multdiv_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] value,
    output logic             tc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (en) begin
            value <= value - 1'b1;
        end
    end

    assign tc = (value == '0);

endmodule : down_counter_load

// File: rtl/multdiv_seq.sv
// ---------------------------------------------------------------------------
// multdiv_seq
//   Control sequencer for the iterative multiplier/divider. Accepts start
//   pulses, strobes the datapath load/step, counts iterations down with a
//   loadable counter and pulses result_rdy when the result is valid.
//   Ports:
//     clk, reset     clock, asynchronous active-high reset
//     ctrl_MULT      start multiply (single-cycle pulse, wins over ctrl_DIV)
//     ctrl_DIV       start divide (single-cycle pulse)
//     divisor_zero   datapath flag, sampled in the LOAD cycle
//     load_ops       datapath: latch operands / init accumulators
//     step_en        datapath: perform one iteration this cycle
//     op_div         1 = current/last op is divide
//     remaining      iterations left after the current one
//     busy           high in LOAD and RUN
//     result_rdy     one-cycle result-valid pulse
//     exception      qualifies result_rdy: divide by zero
// ---------------------------------------------------------------------------
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int MULT_STEPS = DEF_MULT_STEPS,
    parameter int DIV_STEPS  = DEF_DIV_STEPS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             divisor_zero,
    output logic             load_ops,
    output logic             step_en,
    output logic             op_div,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             result_rdy,
    output logic             exception
);

    // Counter preload is STEPS-1 so that remaining==0 marks the last step.
    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_STEPS - 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_STEPS - 1);

    state_t           state, state_nxt;
    logic             start;
    logic             div_zero;
    logic             exc_flag;
    logic             cnt_load;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_ld_val;
    logic             cnt_tc;

    assign start    = ctrl_MULT | ctrl_DIV;
    assign div_zero = op_div & divisor_zero;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        if (start) begin
            // A start in any state (re)launches; an op in flight is abandoned.
            state_nxt = LOAD;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                LOAD:    state_nxt = div_zero ? DONE : RUN;
                RUN:     state_nxt = cnt_tc ? DONE : RUN;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---------------- output decode ----------------
    always_comb begin
        load_ops   = 1'b0;
        step_en    = 1'b0;
        busy       = 1'b0;
        result_rdy = 1'b0;
        exception  = 1'b0;
        case (state)
            LOAD: begin
                load_ops = 1'b1;
                busy     = 1'b1;
            end
            RUN: begin
                step_en = 1'b1;
                busy    = 1'b1;
            end
            DONE: begin
                result_rdy = 1'b1;
                exception  = exc_flag;
            end
            default: ;
        endcase
    end

    // Operation type and divide-by-zero flag. op_div is held through IDLE
    // until the next accepted start; exc_flag is refreshed in every LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_div   <= 1'b0;
            exc_flag <= 1'b0;
        end else begin
            if (ctrl_MULT) begin
                op_div <= 1'b0;
            end else if (ctrl_DIV) begin
                op_div <= 1'b1;
            end
            if (state == LOAD) begin
                exc_flag <= div_zero;
            end
        end
    end

    // A divide-by-zero skips RUN, so load 0 to keep remaining at 0 once the
    // sequencer falls back to IDLE.
    assign cnt_load   = (state == LOAD);
    assign cnt_ld_val = div_zero ? '0 : (op_div ? DIV_LD : MULT_LD);
    assign cnt_en     = (state == RUN) & ~cnt_tc;

    down_counter_load #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_ld_val),
        .en       (cnt_en),
        .value    (remaining),
        .tc       (cnt_tc)
    );

endmodule : multdiv_seq

// File: tb/tb_multdiv_seq.sv
// ---------------------------------------------------------------------------
// tb_multdiv_seq
//   Directed testbench for multdiv_seq. dut0 uses default parameters,
//   dut1 uses MULT_STEPS=2 / DIV_STEPS=64. Both share the stimulus.
// ---------------------------------------------------------------------------
module tb_multdiv_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       ctrl_MULT;
    logic       ctrl_DIV;
    logic       divisor_zero;

    logic       load_ops0, step_en0, op_div0, busy0, result_rdy0, exception0;
    logic [5:0] remaining0;
    logic       load_ops1, step_en1, op_div1, busy1, result_rdy1, exception1;
    logic [5:0] remaining1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    multdiv_seq dut0 (
        .clk          (clk),
        .reset        (reset),
        .ctrl_MULT    (ctrl_MULT),
        .ctrl_DIV     (ctrl_DIV),
        .divisor_zero (divisor_zero),
        .load_ops     (load_ops0),
        .step_en      (step_en0),
        .op_div       (op_div0),
        .remaining    (remaining0),
        .busy         (busy0),
        .result_rdy   (result_rdy0),
        .exception    (exception0)
    );

    multdiv_seq #(
        .MULT_STEPS (2),
        .DIV_STEPS  (64),
        .CNT_W      (6)
    ) dut1 (
        .clk          (clk),
        .reset        (reset),
        .ctrl_MULT    (ctrl_MULT),
        .ctrl_DIV     (ctrl_DIV),
        .divisor_zero (divisor_zero),
        .load_ops     (load_ops1),
        .step_en      (step_en1),
        .op_div       (op_div1),
        .remaining    (remaining1),
        .busy         (busy1),
        .result_rdy   (result_rdy1),
        .exception    (exception1)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive the start pulse, let the next posedge
    // (edge N) sample it, then return at the negedge of cycle N+1.
    task automatic pulse(input logic m, input logic d);
        ctrl_MULT = m;
        ctrl_DIV  = d;
        @(posedge clk);
        @(negedge clk);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Watches up to maxcyc cycles starting with the current cycle (cycle 1 =
    // first cycle after the start edge). Cycle numbers are relative to that.
    task automatic observe(
        input  int   which,
        input  int   maxcyc,
        input  bit   stop_at_rdy,
        output int   load_cyc,
        output int   nsteps,
        output int   first_rem,
        output bit   rem_ok,
        output int   nrdy,
        output int   rdy_cyc,
        output logic exc_rdy,
        output logic opdiv_rdy,
        output logic busy_rdy,
        output logic opdiv_c1,
        output int   end_rem,
        output logic end_busy,
        output logic end_opdiv
    );
        logic       ld, se, od, bz, rr, ex;
        logic [5:0] rm;
        int         prev;
        load_cyc  = -1;
        nsteps    = 0;
        first_rem = -1;
        rem_ok    = 1'b1;
        nrdy      = 0;
        rdy_cyc   = -1;
        exc_rdy   = 1'b0;
        opdiv_rdy = 1'b0;
        busy_rdy  = 1'b0;
        opdiv_c1  = 1'b0;
        prev      = 0;
        end_rem   = 0;
        end_busy  = 1'b0;
        end_opdiv = 1'b0;
        for (int c = 1; c <= maxcyc; c++) begin
            if (c > 1) @(negedge clk);
            if (which == 0) begin
                ld = load_ops0; se = step_en0; od = op_div0; bz = busy0;
                rr = result_rdy0; ex = exception0; rm = remaining0;
            end else begin
                ld = load_ops1; se = step_en1; od = op_div1; bz = busy1;
                rr = result_rdy1; ex = exception1; rm = remaining1;
            end
            if (c == 1) opdiv_c1 = od;
            if (ld && load_cyc < 0) load_cyc = c;
            if (se) begin
                if (nsteps == 0) first_rem = int'(rm);
                else if (int'(rm) != prev - 1) rem_ok = 1'b0;
                prev = int'(rm);
                nsteps++;
            end
            if (rr) begin
                nrdy++;
                if (rdy_cyc < 0) begin
                    rdy_cyc   = c;
                    exc_rdy   = ex;
                    opdiv_rdy = od;
                    busy_rdy  = bz;
                end
            end
            end_rem   = int'(rm);
            end_busy  = bz;
            end_opdiv = od;
            if (rr && stop_at_rdy) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   load_cyc, nsteps, first_rem, nrdy, rdy_cyc, end_rem;
        bit   rem_ok;
        logic exc_rdy, opdiv_rdy, busy_rdy, opdiv_c1, end_busy, end_opdiv;

        reset        = 1'b1;
        ctrl_MULT    = 1'b0;
        ctrl_DIV     = 1'b0;
        divisor_zero = 1'b0;
        #2;
        // Reset state
        check("rst_strobes0", {load_ops0, step_en0, op_div0, busy0, result_rdy0, exception0}, 0);
        check("rst_rem0", remaining0, 0);
        check("rst_strobes1", {load_ops1, step_en1, op_div1, busy1, result_rdy1, exception1}, 0);
        check("rst_rem1", remaining1, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Default multiply: LOAD at N+1, 32 steps 31..0, result_rdy at N+34
        pulse(1'b1, 1'b0);
        observe(0, 40, 1'b0, load_cyc, nsteps, first_rem, rem_ok, nrdy, rdy_cyc,
                exc_rdy, opdiv_rdy, busy_rdy, opdiv_c1, end_rem, end_busy, end_opdiv);
        check("mul_load_cyc", load_cyc, 1);
        check("mul_steps", nsteps, 32);
        check("mul_first_rem", first_rem, 31);
        check("mul_rem_seq", rem_ok, 1);
        check("mul_rdy_cyc", rdy_cyc, 34);
        check("mul_rdy_cnt", nrdy, 1);
        check("mul_exc", exc_rdy, 0);
        check("mul_opdiv", opdiv_rdy, 0);
        check("mul_busy_at_rdy", busy_rdy, 0);
        check("mul_idle_rem", end_rem, 0);
        check("mul_idle_busy", end_busy, 0);

        // Divide by zero: no steps, result_rdy + exception at N+2
        divisor_zero = 1'b1;
        pulse(1'b0, 1'b1);
        observe(0, 6, 1'b0, load_cyc, nsteps, first_rem, rem_ok, nrdy, rdy_cyc,
                exc_rdy, opdiv_rdy, busy_rdy, opdiv_c1, end_rem, end_busy, end_opdiv);
        divisor_zero = 1'b0;
        check("dz_load_cyc", load_cyc, 1);
        check("dz_steps", nsteps, 0);
        check("dz_rdy_cyc", rdy_cyc, 2);
        check("dz_rdy_cnt", nrdy, 1);
        check("dz_exc", exc_rdy, 1);
        check("dz_opdiv", opdiv_rdy, 1);
        check("dz_idle_rem", end_rem, 0);
        check("dz_opdiv_hold", end_opdiv, 1);

        // Restart during RUN: multiply, then divide at RUN cycle 5
        pulse(1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("rs_in_run", step_en0, 1);
        pulse(1'b0, 1'b1);
        observe(0, 40, 1'b0, load_cyc, nsteps, first_rem, rem_ok, nrdy, rdy_cyc,
                exc_rdy, opdiv_rdy, busy_rdy, opdiv_c1, end_rem, end_busy, end_opdiv);
        check("rs_load_cyc", load_cyc, 1);
        check("rs_steps", nsteps, 32);
        check("rs_rdy_cyc", rdy_cyc, 34);
        check("rs_rdy_cnt", nrdy, 1);
        check("rs_opdiv", opdiv_rdy, 1);
        check("rs_exc", exc_rdy, 0);

        // Simultaneous starts (multiply wins), then divide in the DONE cycle
        pulse(1'b1, 1'b1);
        observe(0, 40, 1'b1, load_cyc, nsteps, first_rem, rem_ok, nrdy, rdy_cyc,
                exc_rdy, opdiv_rdy, busy_rdy, opdiv_c1, end_rem, end_busy, end_opdiv);
        check("both_opdiv_c1", opdiv_c1, 0);
        check("both_steps", nsteps, 32);
        check("both_rdy_cyc", rdy_cyc, 34);
        check("both_opdiv", opdiv_rdy, 0);
        pulse(1'b0, 1'b1);
        observe(0, 40, 1'b0, load_cyc, nsteps, first_rem, rem_ok, nrdy, rdy_cyc,
                exc_rdy, opdiv_rdy, busy_rdy, opdiv_c1, end_rem, end_busy, end_opdiv);
        check("b2b_load_cyc", load_cyc, 1);
        check("b2b_opdiv_c1", opdiv_c1, 1);
        check("b2b_steps", nsteps, 32);
        check("b2b_rdy_cyc", rdy_cyc, 34);
        check("b2b_rdy_cnt", nrdy, 1);

        // Reset in the 10th RUN cycle of a multiply
        pulse(1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("rr_in_run", step_en0, 1);
        reset = 1'b1;
        #1;
        check("rr_strobes", {load_ops0, step_en0, op_div0, busy0, result_rdy0, exception0}, 0);
        check("rr_rem", remaining0, 0);
        @(negedge clk);
        reset = 1'b0;
        observe(0, 40, 1'b0, load_cyc, nsteps, first_rem, rem_ok, nrdy, rdy_cyc,
                exc_rdy, opdiv_rdy, busy_rdy, opdiv_c1, end_rem, end_busy, end_opdiv);
        check("rr_no_rdy", nrdy, 0);
        check("rr_no_steps", nsteps, 0);
        check("rr_idle_rem", end_rem, 0);

        // Parameter sweep on dut1: MULT_STEPS=2, DIV_STEPS=64
        pulse(1'b1, 1'b0);
        observe(1, 10, 1'b0, load_cyc, nsteps, first_rem, rem_ok, nrdy, rdy_cyc,
                exc_rdy, opdiv_rdy, busy_rdy, opdiv_c1, end_rem, end_busy, end_opdiv);
        check("sw_mul_steps", nsteps, 2);
        check("sw_mul_first_rem", first_rem, 1);
        check("sw_mul_rdy_cyc", rdy_cyc, 4);
        check("sw_mul_rdy_cnt", nrdy, 1);
        pulse(1'b0, 1'b1);
        observe(1, 70, 1'b0, load_cyc, nsteps, first_rem, rem_ok, nrdy, rdy_cyc,
                exc_rdy, opdiv_rdy, busy_rdy, opdiv_c1, end_rem, end_busy, end_opdiv);
        check("sw_div_steps", nsteps, 64);
        check("sw_div_first_rem", first_rem, 63);
        check("sw_div_rem_seq", rem_ok, 1);
        check("sw_div_rdy_cyc", rdy_cyc, 66);
        check("sw_div_rdy_cnt", nrdy, 1);
        check("sw_div_opdiv", opdiv_rdy, 1);
        check("sw_div_idle_rem", end_rem, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_multdiv_seq
